// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and helper functions for the multiplexed 7-segment driver.
// Glyphs are active-high with bit 6 = segment a down to bit 0 = segment g.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'h7E;
            4'd1:    glyph = 7'h30;
            4'd2:    glyph = 7'h6D;
            4'd3:    glyph = 7'h79;
            4'd4:    glyph = 7'h33;
            4'd5:    glyph = 7'h5B;
            4'd6:    glyph = 7'h5F;
            4'd7:    glyph = 7'h70;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h7B;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

    // Largest value representable with n decimal digits; n <= 8 keeps it within 27 bits.
    function automatic logic [31:0] pow10_m1(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational BCD nibble to active-high glyph lookup; nibbles 10-15 render blank.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = digit_to_seg(digit);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver: sequential binary-to-BCD conversion (shift-add-3)
// feeding a free-running time-multiplexed scan with leading-zero blanking and overflow dashes.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int WIDTH      = 14,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [31:0] MAX_DEC = pow10_m1(DIGITS);
    // Narrow inputs can never exceed the display range, so the compare is gated off entirely.
    localparam bit          OVF_REACHABLE = (64'(MAX_DEC) < ((64'd1 << WIDTH) - 64'd1));
    localparam logic [WIDTH:0] MAX_VAL = MAX_DEC[WIDTH:0];

    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_pend_reg, ovf_pend_next;
    logic               ovf_reg, ovf_next;
    logic [BCD_W-1:0]   disp_reg, disp_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [6:0]         seg_reg, seg_next;
    logic [DIGITS-1:0]  an_reg, an_next;

    logic               ovf_cap;
    logic [BCD_W-1:0]   bcd_adj;
    logic [DIGITS:0]    lz_chain;
    logic [DIGITS-1:0]  blank_mask;
    logic [3:0]         cur_digit;
    logic [6:0]         glyph_lut;
    logic [6:0]         glyph_sel;
    logic [DIGITS-1:0]  an_onehot;

    genvar gi;

    assign ovf_cap = OVF_REACHABLE && ({1'b0, value} > MAX_VAL);

    // Add-3 correction on every nibble that would carry past 9 after the next shift.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        cnt_next      = cnt_reg;
        ovf_pend_next = ovf_pend_reg;
        ovf_next      = ovf_reg;
        disp_next     = disp_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    bin_next      = value;
                    bcd_next      = '0;
                    cnt_next      = '0;
                    ovf_pend_next = ovf_cap;
                    state_next    = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_next = {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
                bin_next = bin_reg << 1;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_next  = bcd_reg;
                ovf_next   = ovf_pend_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pre_next = pre_reg + PRE_W'(1);
        idx_next = idx_reg;
        if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
            pre_next = '0;
            idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // lz_chain[k] is set when digit k and every digit above it are zero.
    assign lz_chain[DIGITS] = 1'b1;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign lz_chain[gi]   = lz_chain[gi+1] && (disp_reg[4*gi +: 4] == 4'd0);
            assign blank_mask[gi] = BLANK_LZ && (gi != 0) && lz_chain[gi];
        end
    endgenerate

    assign cur_digit = disp_reg[{idx_reg, 2'b00} +: 4];

    seg7_digit_lut u_lut (
        .digit (cur_digit),
        .glyph (glyph_lut)
    );

    always_comb begin
        glyph_sel = glyph_lut;
        if (ovf_reg) begin
            glyph_sel = SEG_DASH;
        end else if (blank_mask[idx_reg]) begin
            glyph_sel = SEG_BLANK;
        end
        an_onehot          = '0;
        an_onehot[idx_reg] = 1'b1;
        seg_next = ACTIVE_LOW ? ~glyph_sel : glyph_sel;
        an_next  = ACTIVE_LOW ? ~an_onehot : an_onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            ovf_pend_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            disp_reg     <= '0;
            pre_reg      <= '0;
            idx_reg      <= '0;
            seg_reg      <= SEG_OFF;
            an_reg       <= AN_OFF;
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            cnt_reg      <= cnt_next;
            ovf_pend_reg <= ovf_pend_next;
            ovf_reg      <= ovf_next;
            disp_reg     <= disp_next;
            pre_reg      <= pre_next;
            idx_reg      <= idx_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign ovf  = ovf_reg;
    assign seg  = seg_reg;
    assign an   = an_reg;

endmodule
